// File: rtl/maxpool_window_seq.sv
// maxpool_window_seq
//   Upstream sequencer for the external BANK-lane max-reduction tree. Groups a valid/ready
//   stream of beats into pooling windows of 1..4 beats. It drives the tree's din, repetition
//   and previous_data, and registers each window's final max into a valid/ready output slot.
//
//   Tree timing: the tree registers previous_data/repetition at the clock edge. It then
//   applies the result to din one cycle later. A beat therefore drives mx_rep in its accept
//   cycle, and drives mx_din from the S1 register in the following cycle.
//
//   Optional build macro MAXPOOL_RELU_EN: the captured result is clamped at zero (fused ReLU).
//   The feedback path to the tree is never clamped.
module maxpool_window_seq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BANK       = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 cfg_win_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH*BANK-1:0] in_data,
    output logic [DATA_WIDTH*BANK-1:0] mx_din,
    output logic [1:0]                 mx_rep,
    output logic [DATA_WIDTH-1:0]      mx_prev,
    input  logic [DATA_WIDTH-1:0]      mx_dout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [15:0]                win_done_cnt
);

    // Repetition code that makes the tree re-fold max(din, last) onto itself.
    localparam logic [1:0]  RepHold = 2'b11;
    localparam int unsigned BeatW   = DATA_WIDTH * BANK;

    // S1 stage: the beat currently presented to the tree din.
    logic [BeatW-1:0]      s1_din_q, s1_din_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_last_q, s1_last_d;

    // Window position tracking.
    logic [1:0]            beat_cnt_q, beat_cnt_d;
    logic [1:0]            win_len_q, win_len_d;
    logic [1:0]            eff_len;
    logic                  beat_last;

    // Output slot.
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [15:0]           win_done_cnt_q, win_done_cnt_d;

    logic                  capture;
    logic                  accept;
    logic [DATA_WIDTH-1:0] result;

    // Handshake decode: capture the window max when S1 holds a last beat and the slot is free.
    always_comb begin
        capture  = s1_valid_q & s1_last_q & (~out_valid_q | out_ready);
        // A last beat in S1 blocks the stage until its result has been captured.
        in_ready = ~s1_valid_q | ~s1_last_q | capture;
        accept   = in_valid & in_ready;
        // The first beat of a window uses the live config; later beats use the latched length.
        eff_len   = (beat_cnt_q == 2'd0) ? cfg_win_len : win_len_q;
        beat_last = (beat_cnt_q == eff_len);
    end

    // Tree drive: rep follows the beat position on accept, otherwise holds the running max.
    always_comb begin
        mx_din  = s1_din_q;
        mx_rep  = accept ? beat_cnt_q : RepHold;
        mx_prev = mx_dout;
    end

    // Result shaping at capture; mx_prev above is deliberately taken before this clamp.
    always_comb begin
`ifdef MAXPOOL_RELU_EN
        result = mx_dout[DATA_WIDTH-1] ? '0 : mx_dout;
`else
        result = mx_dout;
`endif
    end

    // Next state for the window counter and the S1 stage.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        win_len_d  = win_len_q;
        s1_din_d   = s1_din_q;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;

        if (accept) begin
            if (beat_cnt_q == 2'd0) begin
                win_len_d = cfg_win_len;
            end
            beat_cnt_d = beat_last ? 2'd0 : beat_cnt_q + 2'd1;
            s1_din_d   = in_data;
            s1_valid_d = 1'b1;
            s1_last_d  = beat_last;
        end else if (!s1_last_q || capture) begin
            // A non-last beat is folded into the tree one cycle after it loads, and a last beat
            // is done once captured. Din is kept, so the tree's hold re-sample stays idempotent.
            s1_valid_d = 1'b0;
        end
    end

    // Next state for the output slot and the completed-window counter.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        win_done_cnt_d = win_done_cnt_q;

        if (capture) begin
            out_valid_d    = 1'b1;
            out_data_d     = result;
            win_done_cnt_d = win_done_cnt_q + 16'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; a reset mid-window discards the partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_din_q       <= '0;
            s1_valid_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            beat_cnt_q     <= 2'd0;
            win_len_q      <= 2'd0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            win_done_cnt_q <= 16'd0;
        end else begin
            s1_din_q       <= s1_din_d;
            s1_valid_q     <= s1_valid_d;
            s1_last_q      <= s1_last_d;
            beat_cnt_q     <= beat_cnt_d;
            win_len_q      <= win_len_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            win_done_cnt_q <= win_done_cnt_d;
        end
    end

    // Output assignments.
    always_comb begin
        out_valid    = out_valid_q;
        out_data     = out_data_q;
        win_done_cnt = win_done_cnt_q;
    end

endmodule

// File: tb/tb_maxpool_window_seq.sv
// Testbench for maxpool_window_seq. Contains a behavioural model of the max-reduction tree.
// It also keeps a window-level scoreboard, a directed vector table, hand sequences for the
// multi-cycle corner cases, and a randomized phase.
module tb_maxpool_window_seq;

    localparam int W  = 8;
    localparam int N  = 32;
    localparam int BW = W * N;
    localparam logic signed [W-1:0] MinVal = 8'sh80;

    logic          clk;
    logic          rst_n;
    logic [1:0]    cfg_win_len;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic [BW-1:0] mx_din;
    logic [1:0]    mx_rep;
    logic [W-1:0]  mx_prev;
    logic [W-1:0]  mx_dout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [15:0]   win_done_cnt;

    maxpool_window_seq #(.DATA_WIDTH(W), .BANK(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_win_len  (cfg_win_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mx_din       (mx_din),
        .mx_rep       (mx_rep),
        .mx_prev      (mx_prev),
        .mx_dout      (mx_dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .win_done_cnt (win_done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tree model. It registers rep/prev at the edge. rep==0 seeds the most negative value,
    // any other code folds onto the previous dout.
    logic [1:0]          tr_rep_q;
    logic signed [W-1:0] tr_prev_q;
    logic signed [W-1:0] tr_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr_rep_q  <= 2'b11;
            tr_prev_q <= MinVal;
        end else begin
            tr_rep_q  <= mx_rep;
            tr_prev_q <= mx_prev;
        end
    end

    always_comb begin
        tr_acc = (tr_rep_q == 2'd0) ? MinVal : tr_prev_q;
        for (int i = 0; i < N; i++) begin
            if ($signed(mx_din[W*i +: W]) > tr_acc) tr_acc = $signed(mx_din[W*i +: W]);
        end
        mx_dout = tr_acc;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Random beat whose largest lane is exactly m.
    function automatic logic [BW-1:0] make_beat(input int m);
        logic [BW-1:0] b;
        int v;
        for (int i = 0; i < N; i++) begin
            v = int'($urandom_range(32'(m + 128), 0)) - 128;
            b[W*i +: W] = v[W-1:0];
        end
        v = m;
        b[W*int'($urandom_range(N - 1, 0)) +: W] = v[W-1:0];
        return b;
    endfunction

    function automatic int beat_max(input logic [BW-1:0] b);
        int mx = -128;
        for (int i = 0; i < N; i++) begin
            if (int'($signed(b[W*i +: W])) > mx) mx = int'($signed(b[W*i +: W]));
        end
        return mx;
    endfunction

    // Window-level reference model and scoreboard, sampled on the falling edge.
    int mq[$];
    int m_cnt     = 0;
    int m_len     = 0;
    int m_cur     = -128;
    int m_windows = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0;
            m_cur = -128;
            m_windows = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (mq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got out_data=%0d, expected no pending window",
                             $signed(out_data));
                end else begin
                    check("sb_out_data", int'($signed(out_data)), mq.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                check("sb_mx_rep_accept", int'(mx_rep), m_cnt);
                if (m_cnt == 0) begin
                    m_len = int'(cfg_win_len);
                    m_cur = -128;
                end
                if (beat_max(in_data) > m_cur) m_cur = beat_max(in_data);
                if (m_cnt == m_len) begin
                    mq.push_back(relu(m_cur));
                    m_windows++;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                check("sb_mx_rep_hold", int'(mx_rep), 3);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [BW-1:0] d);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
    endtask

    typedef struct packed {
        logic [1:0]        wl;
        logic [2:0]        n;
        logic [3:0][W-1:0] m;
        logic [31:0]       exp;
    } vec_t;

    vec_t vecs [0:5];
    int   nv = 0;

    task automatic add_vec(input int wl, input int n, input int a, input int b, input int c,
                           input int d, input int raw_max);
        vecs[nv].wl   = 2'(wl);
        vecs[nv].n    = 3'(n);
        vecs[nv].m[0] = W'(a);
        vecs[nv].m[1] = W'(b);
        vecs[nv].m[2] = W'(c);
        vecs[nv].m[3] = W'(d);
        vecs[nv].exp  = 32'(relu(raw_max));
        nv++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst_n       = 1'b0;
        cfg_win_len = 2'd0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;

        add_vec(3, 4,   10,   40,   -7,   22,   40);
        add_vec(0, 1, -128,    0,    0,    0, -128);
        add_vec(2, 3,   -1,   -2,   -3,    0,   -1);
        add_vec(1, 2,  127, -128,    0,    0,  127);
        add_vec(3, 4, -100,  -90, -110, -128,  -90);
        add_vec(1, 2,    0,   -1,    0,    0,    0);

        // Reset state.
        step();
        step();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_win_done_cnt", int'(win_done_cnt), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_mx_din_zero", int'(mx_din == '0), 1);
        rst_n = 1'b1;
        step();

        // Table-driven windows with out_ready held high.
        out_ready = 1'b1;
        for (int k = 0; k < nv; k++) begin
            cfg_win_len = vecs[k].wl;
            c0 = int'(win_done_cnt);
            for (int j = 0; j < int'(vecs[k].n); j++) begin
                send_beat(make_beat(int'($signed(vecs[k].m[j]))));
                if (j < int'(vecs[k].n) - 1) check("vec_no_early_out", int'(out_valid), 0);
            end
            check("vec_out_valid_latency", int'(out_valid), 0);
            step();
            check("vec_out_valid", int'(out_valid), 1);
            check("vec_out_data", int'($signed(out_data)), int'($signed(vecs[k].exp)));
            check("vec_win_done_cnt", int'(win_done_cnt), c0 + 1);
            step();
            check("vec_out_consumed", int'(out_valid), 0);
        end

        // Back-to-back single-beat windows: results on consecutive cycles.
        cfg_win_len = 2'd0;
        step();
        in_valid = 1'b1;
        in_data  = make_beat(5);
        step();
        check("b2b_idle", int'(out_valid), 0);
        in_data = make_beat(-3);
        step();
        check("b2b_v0", int'(out_valid), 1);
        check("b2b_d0", int'($signed(out_data)), relu(5));
        in_data = make_beat(127);
        step();
        check("b2b_d1", int'($signed(out_data)), relu(-3));
        in_valid = 1'b0;
        step();
        check("b2b_d2", int'($signed(out_data)), relu(127));
        step();
        check("b2b_drained", int'(out_valid), 0);

        // Two-beat window with bubbles between beats.
        cfg_win_len = 2'd1;
        send_beat(make_beat(-50));
        for (int b = 0; b < 3; b++) begin
            step();
            check("bubble_no_out", int'(out_valid), 0);
        end
        send_beat(make_beat(-20));
        check("bubble_no_early", int'(out_valid), 0);
        step();
        check("bubble_out_valid", int'(out_valid), 1);
        check("bubble_out_data", int'($signed(out_data)), relu(-20));
        step();

        // Output stall with two windows pending and a third beat waiting.
        cfg_win_len = 2'd0;
        out_ready   = 1'b0;
        step();
        c0 = int'(win_done_cnt);
        in_valid = 1'b1;
        in_data  = make_beat(11);
        step();
        in_data = make_beat(22);
        step();
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_out_data", int'($signed(out_data)), relu(11));
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_mx_rep", int'(mx_rep), 3);
        in_data = make_beat(33);
        for (int s = 0; s < 2; s++) begin
            step();
            check("stall_hold_data", int'($signed(out_data)), relu(11));
            check("stall_hold_ready", int'(in_ready), 0);
            check("stall_mx_dout", int'($signed(mx_dout)), 22);
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("stall_second_valid", int'(out_valid), 1);
        check("stall_second_data", int'($signed(out_data)), relu(22));
        step();
        check("stall_third_data", int'($signed(out_data)), relu(33));
        check("stall_cnt", int'(win_done_cnt), c0 + 3);
        step();
        check("stall_drained", int'(out_valid), 0);

        // Reset in the middle of a window discards it.
        cfg_win_len = 2'd3;
        send_beat(make_beat(100));
        send_beat(make_beat(90));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_cnt", int'(win_done_cnt), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        step();
        rst_n = 1'b1;
        step();
        for (int j = 1; j <= 4; j++) send_beat(make_beat(j));
        step();
        check("postrst_out_valid", int'(out_valid), 1);
        check("postrst_out_data", int'($signed(out_data)), 4);
        check("postrst_cnt", int'(win_done_cnt), 1);
        step();

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            cfg_win_len = 2'($urandom_range(3, 0));
            in_valid    = ($urandom_range(3, 0) != 0);
            in_data     = make_beat(int'($urandom_range(255, 0)) - 128);
            out_ready   = ($urandom_range(9, 0) < 7);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) step();
        check("rand_drained", mq.size(), 0);
        check("rand_win_done_cnt", int'(win_done_cnt), m_windows & 16'hffff);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
